// File: rtl/interrupt_control_logic_8259a_if.sv
// Bus/IRR-side signal bundle for the 8259A control logic; master drives requests,
// commands and INTA, slave (the controller) returns INT, freeze, clear, ISR and vector.
interface interrupt_control_logic_8259a_if;
   logic [7:0] i_interrupt_request_register;
   logic [7:0] i_interrupt_mask;
   logic       i_interrupt_acknowledge_n;
   logic       i_end_of_interrupt;
   logic       i_specific_eoi;
   logic [2:0] i_eoi_level;
   logic       i_auto_eoi_config;
   logic       i_rotate_on_eoi;
   logic [4:0] i_vector_base;
   logic       o_interrupt_out;
   logic       o_freeze;
   logic [7:0] o_clear_interrupt_request;
   logic [7:0] o_in_service_register;
   logic [7:0] o_vector_out;
   logic       o_vector_valid;

   modport master (
      output i_interrupt_request_register, i_interrupt_mask, i_interrupt_acknowledge_n,
             i_end_of_interrupt, i_specific_eoi, i_eoi_level, i_auto_eoi_config,
             i_rotate_on_eoi, i_vector_base,
      input  o_interrupt_out, o_freeze, o_clear_interrupt_request, o_in_service_register,
             o_vector_out, o_vector_valid
   );

   modport slave (
      input  i_interrupt_request_register, i_interrupt_mask, i_interrupt_acknowledge_n,
             i_end_of_interrupt, i_specific_eoi, i_eoi_level, i_auto_eoi_config,
             i_rotate_on_eoi, i_vector_base,
      output o_interrupt_out, o_freeze, o_clear_interrupt_request, o_in_service_register,
             o_vector_out, o_vector_valid
   );
endinterface

// File: rtl/interrupt_control_logic_8259a.sv
// 8259A priority resolver, ISR keeper and two-pulse INTA sequencer; all outputs registered,
// one cycle after the triggering INTA edge / EOI strobe. No backpressure: INTA edges and EOI act when seen.
module interrupt_control_logic_8259a #(
   parameter logic [2:0] RESET_LOWEST_PRIORITY = 3'd7
) (
   input  logic                            i_clock,
   input  logic                            i_reset,
   interrupt_control_logic_8259a_if.slave  bus
);
   typedef enum logic [0:0] {S_IDLE, S_ACK1} state_t;

   state_t     r_state;
   logic       r_inta_n_d;
   logic [2:0] r_lowest;
   logic [7:0] r_isr;
   logic [2:0] r_winner;
   logic       r_spurious;
   logic       r_int;
   logic       r_freeze;
   logic [7:0] r_clear;
   logic [7:0] r_vector;
   logic       r_vector_valid;

   logic [7:0] w_req;
   logic [2:0] w_lvl;
   logic [2:0] w_win_lvl, w_win_rank, w_top_lvl, w_top_rank;
   logic       w_req_any, w_isr_any, w_eligible, w_edge;
   logic [7:0] w_eoi_clear, w_aeoi_clear, w_isr_set;
   logic [2:0] w_eoi_lvl;
   logic       w_eoi_hit, w_aeoi;

   assign w_req  = bus.i_interrupt_request_register & ~bus.i_interrupt_mask;
   assign w_edge = r_inta_n_d & ~bus.i_interrupt_acknowledge_n;

   // Scan from lowest priority up so the last hit is the highest-priority (rank 0 side) bit.
   always_comb begin
      w_lvl      = 3'd0;
      w_win_lvl  = 3'd0;
      w_win_rank = 3'd7;
      w_req_any  = 1'b0;
      w_top_lvl  = 3'd0;
      w_top_rank = 3'd7;
      w_isr_any  = 1'b0;
      for (int r = 7; r >= 0; r--) begin
         w_lvl = r_lowest + 3'd1 + 3'(r);
         if (w_req[w_lvl]) begin
            w_win_lvl  = w_lvl;
            w_win_rank = 3'(r);
            w_req_any  = 1'b1;
         end
         if (r_isr[w_lvl]) begin
            w_top_lvl  = w_lvl;
            w_top_rank = 3'(r);
            w_isr_any  = 1'b1;
         end
      end
   end

   assign w_eligible = w_req_any && (!w_isr_any || (w_win_rank < w_top_rank));

   always_comb begin
      w_eoi_clear = 8'd0;
      w_eoi_lvl   = 3'd0;
      w_eoi_hit   = 1'b0;
      if (bus.i_end_of_interrupt) begin
         if (bus.i_specific_eoi) begin
            if (r_isr[bus.i_eoi_level]) begin
               w_eoi_hit = 1'b1;
               w_eoi_lvl = bus.i_eoi_level;
            end
         end else if (w_isr_any) begin
            w_eoi_hit = 1'b1;
            w_eoi_lvl = w_top_lvl;
         end
      end
      if (w_eoi_hit) w_eoi_clear = 8'd1 << w_eoi_lvl;
   end

   assign w_isr_set    = (r_state == S_IDLE && w_edge && w_eligible) ? (8'd1 << w_win_lvl) : 8'd0;
   assign w_aeoi       = (r_state == S_ACK1) && w_edge && bus.i_auto_eoi_config && !r_spurious;
   assign w_aeoi_clear = w_aeoi ? (8'd1 << r_winner) : 8'd0;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state        <= S_IDLE;
         r_inta_n_d     <= 1'b1;
         r_lowest       <= RESET_LOWEST_PRIORITY;
         r_isr          <= 8'd0;
         r_winner       <= 3'd0;
         r_spurious     <= 1'b0;
         r_int          <= 1'b0;
         r_freeze       <= 1'b0;
         r_clear        <= 8'd0;
         r_vector       <= 8'd0;
         r_vector_valid <= 1'b0;
      end else begin
         r_inta_n_d     <= bus.i_interrupt_acknowledge_n;
         r_clear        <= 8'd0;
         r_vector_valid <= 1'b0;
         r_isr          <= (r_isr & ~w_eoi_clear & ~w_aeoi_clear) | w_isr_set;
         case (r_state)
            S_IDLE: begin
               if (w_edge) begin
                  r_state    <= S_ACK1;
                  r_freeze   <= 1'b1;
                  r_int      <= 1'b0;
                  r_winner   <= w_eligible ? w_win_lvl : 3'd7;
                  r_spurious <= !w_eligible;
                  r_clear    <= w_isr_set;
               end else begin
                  r_int <= w_eligible;
               end
            end
            default: begin
               r_int <= 1'b0;
               if (w_edge) begin
                  r_state        <= S_IDLE;
                  r_freeze       <= 1'b0;
                  r_vector       <= {bus.i_vector_base, r_winner};
                  r_vector_valid <= 1'b1;
                  if (w_aeoi && bus.i_rotate_on_eoi) r_lowest <= r_winner;
               end
            end
         endcase
         // An explicit EOI rotation takes precedence over a coincident auto-EOI rotation.
         if (w_eoi_hit && bus.i_rotate_on_eoi) r_lowest <= w_eoi_lvl;
      end
   end

   assign bus.o_interrupt_out           = r_int;
   assign bus.o_freeze                  = r_freeze;
   assign bus.o_clear_interrupt_request = r_clear;
   assign bus.o_in_service_register     = r_isr;
   assign bus.o_vector_out              = r_vector;
   assign bus.o_vector_valid            = r_vector_valid;
endmodule
